// File: rtl/dma_pkg.sv
// Shared widths, register offsets and state encodings for the DMA register block.
package dma_pkg;

  localparam int REG_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [REG_ADDR_WIDTH-1:0] SRC_OFFSET  = 32'h00;
  localparam logic [REG_ADDR_WIDTH-1:0] DEST_OFFSET = 32'h04;
  localparam logic [REG_ADDR_WIDTH-1:0] SIZE_OFFSET = 32'h08;
  localparam logic [REG_ADDR_WIDTH-1:0] MODE_OFFSET = 32'h0C;
  localparam logic [REG_ADDR_WIDTH-1:0] INT_OFFSET  = 32'h10;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_VERIFY = 2'd2
  } dma_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/dma_apb_slv_fsm.sv
// APB3 completer handshake: one wait state, PREADY registered and high for one cycle.
// Latency: PREADY in the 2nd access cycle; the transfer is aborted if PSEL drops before the response.
module dma_apb_slv_fsm
  import dma_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [REG_ADDR_WIDTH-1:0] paddr,
  output logic                      pready,
  output logic                      access,
  output logic                      wr_en,
  output logic                      rd_en,
  output logic [4:0]                reg_sel,
  output logic                      addr_err
);

  apb_state_e state_q, state_d, phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pready  <= 1'b0;
    end else begin
      state_q <= state_d;
      pready  <= (state_d == ST_RESP);
    end
  end

  // SETUP becomes ACCESS in the very cycle PENABLE is seen, which keeps this to one wait state
  always_comb begin
    phase = state_q;
    if (state_q == ST_SETUP && psel && penable)
      phase = ST_ACCESS;
    state_d = phase;
    access  = 1'b0;
    case (phase)
      ST_IDLE:   if (psel && !penable) state_d = ST_SETUP;
      ST_SETUP:  if (!psel) state_d = ST_IDLE;
      ST_ACCESS: begin
        state_d = ST_RESP;
        access  = 1'b1;
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign rd_en = access & ~pwrite;
  assign wr_en = (state_q == ST_RESP) & psel & penable & pwrite & pready;

  // Misaligned addresses match no offset and fall into the error case
  always_comb begin
    reg_sel = 5'b00000;
    case (paddr)
      SRC_OFFSET:  reg_sel = 5'b00001;
      DEST_OFFSET: reg_sel = 5'b00010;
      SIZE_OFFSET: reg_sel = 5'b00100;
      MODE_OFFSET: reg_sel = 5'b01000;
      INT_OFFSET:  reg_sel = 5'b10000;
      default:     reg_sel = 5'b00000;
    endcase
    addr_err = ~|reg_sel;
  end

endmodule

// File: rtl/dma_apb_regs.sv
// DMA configuration/control registers behind an APB3 completer; start pulses, busy tracking, INTR.
// Latency: writes land on the edge ending the response cycle, start_* the cycle after; PREADY gives one wait state.
module dma_apb_regs
  import dma_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [REG_ADDR_WIDTH-1:0] PADDR,
  input  logic [REG_DATA_WIDTH-1:0] PWDATA,
  output logic [REG_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      INTR,
  output logic [REG_DATA_WIDTH-1:0] src_addr,
  output logic [REG_DATA_WIDTH-1:0] dst_addr,
  output logic [REG_DATA_WIDTH-1:0] xfer_size,
  output logic                      start_dma,
  output logic                      start_verify,
  input  logic                      dma_done,
  input  logic                      verify_done
);

  logic [4:0]                reg_sel;
  logic                      addr_err, access, wr_en, rd_en;
  logic [REG_DATA_WIDTH-1:0] mode_q, int_q, rdata;
  logic                      busy, done_hit, busy_err, xfer_err, wr_ok;

  dma_apb_slv_fsm u_fsm (
    .clk      (CLK),
    .rst      (RST),
    .psel     (PSEL),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .paddr    (PADDR),
    .pready   (PREADY),
    .access   (access),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .reg_sel  (reg_sel),
    .addr_err (addr_err)
  );

  assign done_hit = busy & (dma_done | verify_done);
  assign busy_err = PWRITE & busy & (|reg_sel[2:0]);
  assign xfer_err = addr_err | busy_err;
  // PSLVERR still holds the decision made in the access cycle, so it vetoes the commit
  assign wr_ok    = wr_en & ~PSLVERR;
  assign INTR     = int_q[0];

  always_comb begin
    rdata = '0;
    if (reg_sel[0])      rdata = src_addr;
    else if (reg_sel[1]) rdata = dst_addr;
    else if (reg_sel[2]) rdata = xfer_size;
    else if (reg_sel[3]) rdata = mode_q;
    else if (reg_sel[4]) rdata = int_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else if (access) begin
      PRDATA  <= (rd_en && !addr_err) ? rdata : '0;
      PSLVERR <= xfer_err;
    end else begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end
  end

  // Completion clear comes first so a MODE write on the same edge overrides it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      src_addr     <= '0;
      dst_addr     <= '0;
      xfer_size    <= '0;
      mode_q       <= '0;
      int_q        <= '0;
      busy         <= 1'b0;
      start_dma    <= 1'b0;
      start_verify <= 1'b0;
    end else begin
      start_dma    <= 1'b0;
      start_verify <= 1'b0;
      if (done_hit) begin
        mode_q   <= '0;
        busy     <= 1'b0;
        int_q[0] <= 1'b1;
      end
      if (wr_ok) begin
        if (reg_sel[0]) src_addr  <= PWDATA;
        if (reg_sel[1]) dst_addr  <= PWDATA;
        if (reg_sel[2]) xfer_size <= PWDATA;
        if (reg_sel[3]) begin
          mode_q <= PWDATA;
          if (PWDATA == REG_DATA_WIDTH'(MODE_NORMAL)) begin
            start_dma <= 1'b1;
            busy      <= 1'b1;
          end else if (PWDATA == REG_DATA_WIDTH'(MODE_VERIFY)) begin
            start_verify <= 1'b1;
            busy         <= 1'b1;
          end
        end
        if (reg_sel[4]) int_q <= {PWDATA[REG_DATA_WIDTH-1:1], PWDATA[0] | done_hit};
      end
    end
  end

endmodule

// File: tb/tb_dma_apb_regs.sv
// Directed bench for dma_apb_regs: APB register map, error responses, start/done handling, reset.
`timescale 1ns/1ps
module tb_dma_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr, intr;
  logic [31:0] src_addr, dst_addr, xfer_size;
  logic        start_dma, start_verify, dma_done, verify_done;

  int checks = 0;
  int errors = 0;
  int dma_pulses = 0;
  int verify_pulses = 0;
  int done_at_commit = 0;

  dma_apb_regs dut (
    .CLK          (clk),
    .RST          (rst),
    .PSEL         (psel),
    .PENABLE      (penable),
    .PWRITE       (pwrite),
    .PADDR        (paddr),
    .PWDATA       (pwdata),
    .PRDATA       (prdata),
    .PREADY       (pready),
    .PSLVERR      (pslverr),
    .INTR         (intr),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .xfer_size    (xfer_size),
    .start_dma    (start_dma),
    .start_verify (start_verify),
    .dma_done     (dma_done),
    .verify_done  (verify_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_dma)    dma_pulses++;
    if (start_verify) verify_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer; optionally fires a done pulse on the edge that completes it
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int waits;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("wait_states", 32'(waits), 32'd1);
    rdata = prdata;
    err   = pslverr;
    if (done_at_commit == 1)      dma_done = 1'b1;
    else if (done_at_commit == 2) verify_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; dma_done = 1'b0; verify_done = 1'b0; done_at_commit = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input string tag);
    logic [31:0] unused_rd;
    logic        e;
    apb_xfer(1'b1, a, d, unused_rd, e);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err, input string tag);
    logic [31:0] d;
    logic        e;
    apb_xfer(1'b0, a, 32'h0, d, e);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic pulse_dma_done();
    @(posedge clk); #1 dma_done = 1'b1;
    @(posedge clk); #1 dma_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; dma_done = 1'b0; verify_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",  32'(pready),       32'd0);
    chk("rst_pslverr", 32'(pslverr),      32'd0);
    chk("rst_prdata",  prdata,            32'd0);
    chk("rst_intr",    32'(intr),         32'd0);
    chk("rst_start",   32'({start_dma, start_verify}), 32'd0);
    chk("rst_src",     src_addr,          32'd0);
    rst = 1'b0;

    // Register map walk
    for (int i = 0; i < 5; i++) wr(32'(4 * i), 32'(i), 1'b0, "map_wr");
    for (int i = 0; i < 5; i++) rd_chk(32'(4 * i), 32'(i), 1'b0, "map_rd");
    chk("mode3_no_start", 32'(dma_pulses + verify_pulses), 32'd0);

    // Unmapped and misaligned accesses
    rd_chk(32'h14, 32'h0, 1'b1, "unmapped_rd");
    rd_chk(32'h02, 32'h0, 1'b1, "misaligned_rd");
    wr(32'h14, 32'hFFFF_FFFF, 1'b1, "unmapped_wr");
    wr(32'h01, 32'h0000_AAAA, 1'b1, "misaligned_wr");
    chk("err_src_kept",  src_addr,  32'd0);
    chk("err_dst_kept",  dst_addr,  32'd1);
    chk("err_size_kept", xfer_size, 32'd2);
    rd_chk(32'h10, 32'd4, 1'b0, "err_int_kept");

    // Program and start a normal transfer
    wr(32'h00, 32'h0010_0007, 1'b0, "src");
    wr(32'h04, 32'h0020_0002, 1'b0, "dst");
    wr(32'h08, 32'd11, 1'b0, "size");
    wr(32'h0C, 32'd1, 1'b0, "mode_normal");
    chk("start_dma_pulse", 32'(start_dma), 32'd1);
    @(posedge clk); #1;
    chk("start_dma_single", 32'(start_dma), 32'd0);
    chk("dma_pulse_count", 32'(dma_pulses), 32'd1);
    chk("verify_pulse_none", 32'(verify_pulses), 32'd0);
    wr(32'h08, 32'd5, 1'b1, "size_busy");
    rd_chk(32'h08, 32'd11, 1'b0, "size_busy_rd");
    chk("src_port", src_addr, 32'h0010_0007);
    chk("dst_port", dst_addr, 32'h0020_0002);

    // Completion
    pulse_dma_done();
    chk("intr_after_done", 32'(intr), 32'd1);
    rd_chk(32'h0C, 32'd0, 1'b0, "mode_cleared");
    wr(32'h10, 32'd0, 1'b0, "int_clr");
    chk("intr_cleared", 32'(intr), 32'd0);
    pulse_dma_done();
    chk("idle_done_ignored", 32'(intr), 32'd0);
    wr(32'h08, 32'd12, 1'b0, "size_after_done");
    chk("size_port", xfer_size, 32'd12);

    // Verify run; done coincides with software clearing INT
    wr(32'h0C, 32'd2, 1'b0, "mode_verify");
    chk("start_verify_pulse", 32'(start_verify), 32'd1);
    done_at_commit = 2;
    wr(32'h10, 32'd0, 1'b0, "int_clr_race");
    chk("intr_hw_wins", 32'(intr), 32'd1);
    rd_chk(32'h10, 32'd1, 1'b0, "int_race_rd");
    rd_chk(32'h0C, 32'd0, 1'b0, "mode_after_verify");
    chk("verify_pulse_count", 32'(verify_pulses), 32'd1);

    // Abort in setup: PSEL drops instead of PENABLE rising
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'd1;
    @(posedge clk); #1;
    psel = 1'b0;
    // Abort in the response cycle: PSEL drops before the completing edge
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_pulse", 32'(dma_pulses), 32'd1);
    chk("abort_src_kept", src_addr, 32'h0010_0007);
    rd_chk(32'h0C, 32'd0, 1'b0, "abort_mode");

    // MODE write racing a done pulse: the write wins and starts again
    wr(32'h0C, 32'd1, 1'b0, "mode_normal2");
    done_at_commit = 1;
    wr(32'h0C, 32'd1, 1'b0, "mode_race");
    chk("race_start_pulse", 32'(start_dma), 32'd1);
    @(posedge clk); #1;
    chk("race_pulse_count", 32'(dma_pulses), 32'd3);
    rd_chk(32'h0C, 32'd1, 1'b0, "race_mode_rd");
    wr(32'h08, 32'd7, 1'b1, "race_still_busy");

    // Reset during the access phase while busy
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pready",  32'(pready),  32'd0);
    chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
    chk("mid_rst_prdata",  prdata,       32'd0);
    chk("mid_rst_intr",    32'(intr),    32'd0);
    chk("mid_rst_start",   32'({start_dma, start_verify}), 32'd0);
    chk("mid_rst_src",     src_addr,     32'd0);
    chk("mid_rst_size",    xfer_size,    32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rd_chk(32'h0C, 32'd0, 1'b0, "mode_after_rst");
    wr(32'h08, 32'd3, 1'b0, "size_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_apb_regs.md
# dma_apb_regs

APB3 completer (slave) holding the DMA configuration and control registers (SRC, DEST, SIZE, MODE, INT). It is the responder for the APB master path and sits between the APB bus and the DMA engine/verifier inside the DUT. It decodes register accesses with one wait state, drives start pulses to the engine, auto-clears MODE on completion, and raises INTR.

## Interface
- REG_ADDR_WIDTH, 32 (dma_pkg): PADDR width.
- REG_DATA_WIDTH, 32 (dma_pkg): PWDATA/PRDATA and register width.
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  reset, asynchronous and active-high.
- PSEL, PENABLE, PWRITE  in  1 each  APB select, access phase, direction.
- PADDR  in  REG_ADDR_WIDTH  byte address.
- PWDATA  in  REG_DATA_WIDTH  write data.
- PRDATA  out  REG_DATA_WIDTH  read data, registered; valid only while PREADY=1.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, qualified by PREADY.
- INTR  out  1  equals INT[0].
- src_addr, dst_addr, xfer_size  out  REG_DATA_WIDTH each  register contents.
- start_dma  out  1  one-cycle pulse; MODE written with 1.
- start_verify  out  1  one-cycle pulse; MODE written with 2.
- dma_done, verify_done  in  1 each  single-cycle completion pulses from engine/verifier.

## Operation
- Map (PADDR offset): 0x00 SRC, 0x04 DEST, 0x08 SIZE, 0x0C MODE, 0x10 INT. All 32-bit read/write. Reset value 0.
- Unmapped offset (>0x10), or PADDR[1:0]!=0: PSLVERR=1, write dropped, PRDATA=0.
- MODE: any value is stored and reads back. Writing 1 pulses start_dma. Writing 2 pulses start_verify. Either sets internal busy. Other values store only.
- Busy: while busy, writes to SRC/DEST/SIZE are dropped with PSLVERR=1. Reads are always allowed.
- dma_done while busy: MODE←0, busy←0, INT[0]←1. verify_done is handled the same way. Done pulses while not busy are ignored.
- INT: plain RW storage; software clears INT[0] by writing 0. A hardware set of INT[0] in the same cycle as a software write to INT wins for bit 0 only.
- Done and APB write to MODE completing in the same cycle: clear is applied first, then the write. The write wins and may start a new operation.

## Timing
- FSM states are IDLE → SETUP → ACCESS → RESP → IDLE.
  - IDLE→SETUP on PSEL & !PENABLE.
  - SETUP→ACCESS on PENABLE.
  - ACCESS→RESP unconditionally, loading PRDATA/PSLVERR and setting PREADY=1.
  - RESP: PREADY drops next cycle.
- Result: every transfer completes in the 2nd ACCESS-phase cycle (one wait state).
- Register writes and start pulses take effect on the edge ending RESP (PSEL&PENABLE&PREADY). start_* is high for the following cycle.
- Read data is sampled at the ACCESS→RESP edge.
- PSEL dropped before RESP: abort to IDLE, no write, no pulse.
- INTR rises the cycle after the done pulse.
- RST, including mid-transfer or mid-DMA: all registers, busy and FSM cleared. PREADY=0, PSLVERR=0, PRDATA=0, start_*=0, INTR=0.

## Structure
- dma_pkg holds REG_ADDR_WIDTH, REG_DATA_WIDTH, the five offset constants, a mode enum (IDLE=0, NORMAL=1, VERIFY=2), and the FSM state typedef.
- Sub-module dma_apb_slv_fsm implements the handshake FSM and produces wr_en/rd_en/addr strobes. The register file, busy, INT logic and pulses stay in dma_apb_regs.

## Test plan
- Write i to offset 4·i for i=0..4, read each back → 0,1,2,3,4. PSLVERR=0. No start pulse for MODE=3.
- Read 0x14 and 0x02 → PSLVERR=1, PRDATA=0. No register changes.
- Set SRC=0x00100007, DEST=0x00200002, SIZE=11, then MODE=1 → one start_dma pulse. A write to SIZE now gives PSLVERR=1 and SIZE stays 11.
- Pulse dma_done → next cycle INTR=1, MODE reads 0. Write INT=0 → INTR=0.
- MODE=2 then verify_done coincident with a software write INT=0 → INT[0]=1, MODE=0.
- Assert RST during ACCESS with busy=1 → all outputs 0 immediately. A read of MODE after reset returns 0.
